mem_loader: RTL and testbench

- Initiator-side program loader for the 32-word unified memory of the multicycle RISC.
- Receives a byte stream from a host link over a valid/ready handshake and assembles 16-bit words, high byte first.
- Issues sequential single-cycle writes to memory addresses 0..DEPTH-1.
- Holds the processor in reset until the image is complete; sits beside the core and muxes onto the memory write port while `hold_proc` is high.

---
 rtl/mem_loader_pkg.sv | 17 +
 rtl/mem_loader_if.sv | 17 +
 rtl/byte_to_word_packer.sv | 34 +++
 rtl/mem_loader.sv | 123 ++++++++++++
 tb/tb_mem_loader.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/mem_loader_pkg.sv
// Shared types and sizes for the program loader of the multicycle RISC.
// State set grows CHECK/ERROR when MEM_LOADER_CHECKSUM_EN is defined.
package mem_loader_pkg;
  localparam int MEM_ADDR_W = 5;
  localparam int MEM_DATA_W = 16;
  localparam int LOAD_DEPTH = 32;

`ifdef MEM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    IDLE, WAIT_HI, WAIT_LO, WRITE, DONE, CHECK, ERROR
  } loader_state_e;
`else
  typedef enum logic [2:0] {
    IDLE, WAIT_HI, WAIT_LO, WRITE, DONE
  } loader_state_e;
`endif
endpackage

// File: rtl/mem_loader_if.sv
// Host byte link plus memory write port of the loader.
interface mem_loader_if import mem_loader_pkg::*; #(
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int DATA_W = MEM_DATA_W
) ();
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic              mem_write;

  modport master (input rx_data, rx_valid,
                  output rx_ready, mem_addr, mem_data, mem_write);
  modport slave  (output rx_data, rx_valid,
                  input rx_ready, mem_addr, mem_data, mem_write);
endinterface

// File: rtl/byte_to_word_packer.sv
// Byte handshake and high-byte-first word assembly; word_vld flags the low-byte handshake.
module byte_to_word_packer #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              clr,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              byte_fire,
  output logic              word_vld,
  output logic [DATA_W-1:0] word
);
  logic lo_phase;

  assign rx_ready  = en;
  assign byte_fire = en && rx_valid;
  assign word_vld  = byte_fire && lo_phase;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lo_phase <= 1'b0;
      word     <= '0;
    end else if (clr) begin
      lo_phase <= 1'b0;
    end else if (byte_fire) begin
      lo_phase <= !lo_phase;
      if (lo_phase) word[7:0]          <= rx_data;
      else          word[DATA_W-1 -: 8] <= rx_data;
    end
  end
endmodule

// File: rtl/mem_loader.sv
// Loads DEPTH words from a byte stream into memory addresses 0..DEPTH-1, holding the core meanwhile.
// Optional trailer checksum: define MEM_LOADER_CHECKSUM_EN.
module mem_loader import mem_loader_pkg::*; #(
  parameter int DEPTH  = LOAD_DEPTH,
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int DATA_W = MEM_DATA_W
) (
  input  logic         clk,
  input  logic         proc_rst_n,
  input  logic         start,
  mem_loader_if.master bus,
  output logic         hold_proc,
  output logic         busy,
  output logic         done,
  output logic         error
);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  loader_state_e state;
  logic rx_en, byte_fire, word_vld, start_ok;

  byte_to_word_packer #(.DATA_W(DATA_W)) u_packer (
    .clk       (clk),
    .rst_n     (proc_rst_n),
    .en        (rx_en),
    .clr       (start_ok),
    .rx_data   (bus.rx_data),
    .rx_valid  (bus.rx_valid),
    .rx_ready  (bus.rx_ready),
    .byte_fire (byte_fire),
    .word_vld  (word_vld),
    .word      (bus.mem_data)
  );

`ifdef MEM_LOADER_CHECKSUM_EN
  logic [7:0] sum;
  logic [7:0] sum_next;
  logic       err_q;
  assign sum_next = sum + bus.rx_data;
  assign error    = err_q;
  assign start_ok = start && (state == IDLE || state == DONE || state == ERROR);
`else
  assign error    = 1'b0;
  assign start_ok = start && (state == IDLE || state == DONE);
`endif

  always_ff @(posedge clk or negedge proc_rst_n) begin
    if (!proc_rst_n) begin
      state         <= IDLE;
      bus.mem_addr  <= '0;
      bus.mem_write <= 1'b0;
      rx_en         <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      hold_proc     <= 1'b1;
`ifdef MEM_LOADER_CHECKSUM_EN
      sum           <= '0;
      err_q         <= 1'b0;
`endif
    end else begin
      bus.mem_write <= 1'b0;
`ifdef MEM_LOADER_CHECKSUM_EN
      if (byte_fire && state != CHECK) sum <= sum_next;
`endif
      if (start_ok) begin
        state        <= WAIT_HI;
        bus.mem_addr <= '0;
        rx_en        <= 1'b1;
        busy         <= 1'b1;
        done         <= 1'b0;
        hold_proc    <= 1'b1;
`ifdef MEM_LOADER_CHECKSUM_EN
        sum          <= '0;
        err_q        <= 1'b0;
`endif
      end else begin
        case (state)
          WAIT_HI: if (byte_fire) state <= WAIT_LO;
          WAIT_LO: if (word_vld) begin
            state         <= WRITE;
            bus.mem_write <= 1'b1;
            rx_en         <= 1'b0;
          end
          WRITE: begin
            if (bus.mem_addr == LAST) begin
`ifdef MEM_LOADER_CHECKSUM_EN
              state     <= CHECK;
              rx_en     <= 1'b1;
`else
              state     <= DONE;
              busy      <= 1'b0;
              done      <= 1'b1;
              hold_proc <= 1'b0;
`endif
            end else begin
              bus.mem_addr <= bus.mem_addr + ADDR_W'(1);
              state        <= WAIT_HI;
              rx_en        <= 1'b1;
            end
          end
`ifdef MEM_LOADER_CHECKSUM_EN
          // Trailer byte makes the whole image sum to zero mod 256.
          CHECK: if (byte_fire) begin
            rx_en <= 1'b0;
            busy  <= 1'b0;
            if (sum_next == 8'd0) begin
              state     <= DONE;
              done      <= 1'b1;
              hold_proc <= 1'b0;
            end else begin
              state <= ERROR;
              err_q <= 1'b1;
            end
          end
          ERROR: ;
`endif
          IDLE, DONE: ;
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_mem_loader.sv
// Scoreboarded random bench for mem_loader: expected writes are queued per load, a monitor checks each mem_write.
module tb_mem_loader;
  typedef logic [7:0] bq_t[$];
  typedef struct { logic [4:0] addr; logic [15:0] data; } wr_t;

  logic       clk = 1'b0;
  logic       proc_rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       hold_proc, busy, done, error;
  int         vectors = 0;
  int         fails = 0;
  wr_t        exp_q[$];

  always #5 clk = ~clk;

  mem_loader_if bus ();
  assign bus.rx_data  = rx_data;
  assign bus.rx_valid = rx_valid;

  mem_loader dut (
    .clk        (clk),
    .proc_rst_n (proc_rst_n),
    .start      (start),
    .bus        (bus),
    .hold_proc  (hold_proc),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0h, want %0h", nm, act, expv);
    end
  endtask

  // Monitor: every write must match the head of the expected queue.
  always @(negedge clk) begin
    if (bus.mem_write === 1'b1) begin
      chk("rx_ready_in_write", 32'(bus.rx_ready), 32'd0);
      chk("hold_in_write", 32'(hold_proc), 32'd1);
      if (exp_q.size() == 0) begin
        chk("unexpected_write_addr", 32'(bus.mem_addr), 32'hFFFF_FFFF);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("write_addr", 32'(bus.mem_addr), 32'(e.addr));
        chk("write_data", 32'(bus.mem_data), 32'(e.data));
      end
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_bytes(input bq_t bytes, input int pv, output int edges);
    int i;
    i = 0;
    edges = 0;
    while (i < bytes.size() && edges < 5000) begin
      rx_valid = ($urandom_range(99) < pv);
      rx_data  = rx_valid ? bytes[i] : 8'($urandom);
      @(negedge clk);
      if (rx_valid && bus.rx_ready) i++;
      @(posedge clk); #1;
      edges++;
    end
    rx_valid = 1'b0;
    chk("bytes_consumed", 32'(i), 32'(bytes.size()));
  endtask

  // Queue the image's expected writes, start, stream bytes (plus trailer when checksummed).
  task automatic run_load(input bq_t data, input int pv, input int trl_adj, output int edges);
    bq_t s;
    logic [7:0] sum;
    s = data;
    sum = 8'd0;
    for (int k = 0; k < 32; k++)
      exp_q.push_back('{addr: 5'(k), data: {data[2*k], data[2*k+1]}});
    foreach (data[j]) sum = sum + data[j];
`ifdef MEM_LOADER_CHECKSUM_EN
    s.push_back(8'(8'd0 - sum + 8'(trl_adj)));
`else
    if (trl_adj != 0) sum = 8'd0;
`endif
    pulse_start();
    send_bytes(s, pv, edges);
  endtask

  task automatic wait_end(input int from, output int n);
    n = from;
    while (!(done || error) && n < from + 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("load_finished", 32'(done || error), 32'd1);
  endtask

  function automatic bq_t rand_image();
    bq_t q;
    for (int j = 0; j < 64; j++) q.push_back(8'($urandom));
    return q;
  endfunction

  initial begin
    bq_t img;
    int  edges, n;

    // Reset state
    #12;
    chk("rst_hold", 32'(hold_proc), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_write", 32'(bus.mem_write), 32'd0);
    chk("rst_ready", 32'(bus.rx_ready), 32'd0);
    chk("rst_addr", 32'(bus.mem_addr), 32'd0);
    chk("rst_data", 32'(bus.mem_data), 32'd0);
    @(negedge clk); proc_rst_n = 1'b1;
    @(posedge clk); #1;

    // Full load, valid always high, counting pattern
    img = {};
    for (int k = 0; k < 64; k++) img.push_back(8'(k));
    run_load(img, 100, 0, edges);
    wait_end(edges, n);
`ifdef MEM_LOADER_CHECKSUM_EN
    chk("done_cycle", 32'(n), 32'd97);
`else
    chk("done_cycle", 32'(n), 32'd96);
`endif
    chk("full_done", 32'(done), 32'd1);
    chk("full_hold", 32'(hold_proc), 32'd0);
    chk("full_busy", 32'(busy), 32'd0);
    chk("full_all_written", 32'(exp_q.size()), 32'd0);

    // Extra byte after completion is not accepted
    rx_valid = 1'b1; rx_data = 8'hA5;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("done_rx_ready", 32'(bus.rx_ready), 32'd0);
    end
    rx_valid = 1'b0;
    chk("done_error", 32'(error), 32'd0);
    chk("done_sticky", 32'(done), 32'd1);

    // Backpressure with random data, start pulsed mid-load is ignored
    img = rand_image();
    fork
      run_load(img, 50, 0, edges);
      begin
        int g;
        g = 0;
        @(posedge clk); #1;
        while (bus.mem_addr != 5'd10 && g < 3000) begin @(posedge clk); #1; g++; end
        chk("reached_word10", 32'(bus.mem_addr), 32'd10);
        pulse_start();
        chk("busy_after_ignored_start", 32'(busy), 32'd1);
      end
    join
    wait_end(edges, n);
    chk("bp_done", 32'(done), 32'd1);
    chk("bp_all_written", 32'(exp_q.size()), 32'd0);

    // Start in DONE restarts from address 0
    img = rand_image();
    for (int k = 0; k < 32; k++)
      exp_q.push_back('{addr: 5'(k), data: {img[2*k], img[2*k+1]}});
    pulse_start();
    chk("restart_hold", 32'(hold_proc), 32'd1);
    chk("restart_done", 32'(done), 32'd0);
    chk("restart_busy", 32'(busy), 32'd1);
    chk("restart_addr", 32'(bus.mem_addr), 32'd0);
`ifdef MEM_LOADER_CHECKSUM_EN
    begin
      logic [7:0] s8;
      s8 = 8'd0;
      foreach (img[j]) s8 = s8 + img[j];
      img.push_back(8'(8'd0 - s8));
    end
`endif
    send_bytes(img, 70, edges);
    wait_end(edges, n);
    chk("restart_all_written", 32'(exp_q.size()), 32'd0);

    // Reset mid WAIT_LO after three words
    img = rand_image();
    for (int k = 0; k < 3; k++)
      exp_q.push_back('{addr: 5'(k), data: {img[2*k], img[2*k+1]}});
    img = img[0:6];
    pulse_start();
    send_bytes(img, 100, edges);
    @(negedge clk); #2;
    proc_rst_n = 1'b0;
    #1;
    chk("abort_write", 32'(bus.mem_write), 32'd0);
    chk("abort_hold", 32'(hold_proc), 32'd1);
    chk("abort_addr", 32'(bus.mem_addr), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk); proc_rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("abort_writes_seen", 32'(exp_q.size()), 32'd0);
    chk("abort_idle_busy", 32'(busy), 32'd0);

`ifdef MEM_LOADER_CHECKSUM_EN
    img = {};
    for (int k = 0; k < 64; k++) img.push_back(8'h01);
    run_load(img, 100, 0, edges);
    wait_end(edges, n);
    chk("cks_good_done", 32'(done), 32'd1);
    chk("cks_good_error", 32'(error), 32'd0);
    run_load(img, 100, 1, edges);
    wait_end(edges, n);
    chk("cks_bad_error", 32'(error), 32'd1);
    chk("cks_bad_done", 32'(done), 32'd0);
    chk("cks_bad_hold", 32'(hold_proc), 32'd1);
    chk("cks_bad_busy", 32'(busy), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
